out_checker: RTL and testbench
==============================

# out_checker

Self-checking monitor that sits directly downstream of the example top-level and consumes its outputs together with the stimulus that produced them. For each sampled cycle it recomputes the expected out_small/out_quad/out_wide values (zero while the DUT is held in reset, otherwise input + 1 modulo lane width) and counts checks and mismatches. Mismatch records go into a small FIFO that the C++ harness drains through a valid/ready port. A three-state FSM stops logging once an error limit is reached.

## Interface
- SMALL_W, 2, width of the small lane
- QUAD_W, 40, width of the quad lane
- WIDE_W, 70, width of the wide lane
- LOG_AW, 3, log FIFO address width; depth = 2**LOG_AW
- ERR_LIMIT, 4, mismatch count that forces FAIL; must be 1 to 65535
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sample_en  in  1  sample the current DUT inputs and outputs this cycle
- clear  in  1  synchronous; returns FSM to IDLE and clears counters, FIFO and stickies
- dut_reset_l  in  1  DUT reset as applied to the DUT (active-low)
- in_small / in_quad / in_wide  in  SMALL_W / QUAD_W / WIDE_W  DUT stimulus
- out_small / out_quad / out_wide  in  SMALL_W / QUAD_W / WIDE_W  DUT results
- check_count  out  32  checks performed; saturates at 0xFFFF_FFFF
- err_count  out  16  mismatching checks; saturates at 0xFFFF
- fail  out  1  high in FAIL state
- overflow  out  1  sticky; a log record was dropped
- log_valid  out  1  FIFO non-empty
- log_ready  in  1  consumer accepts the head record
- log_data  out  19  {lane_mask[2:0] (bit2 wide, bit1 quad, bit0 small), stamp[15:0]}

## Operation
- Stage 1: when sample_en=1, register all inputs plus dut_reset_l, and set v1=1. Otherwise v1=0.
- Stage 2, when v1=1:
  - Expected value per lane is 0 if the registered dut_reset_l=0, else the registered in + 1 truncated to the lane width. Example: in_small=2'b11 gives 2'b00.
  - lane_mask bit = (out != expected).
  - mismatch = |lane_mask.
- stamp is a 16-bit free-running cycle counter. It starts at 0 after reset or clear, wraps at 0xFFFF, and its stage-2 value is what gets recorded.
- FSM states:
  - IDLE: no checks are counted. Moves to RUN on the first cycle with sample_en=1; that sample is checked.
  - RUN: every v1 increments check_count. Each mismatch increments err_count and pushes {lane_mask, stamp}. When err_count reaches ERR_LIMIT, the FSM moves to FAIL on the same edge as the increment.
  - FAIL: check_count and err_count keep counting, but no FIFO pushes occur. The FIFO can still be drained. Only clear or reset leaves FAIL.
- The ERR_LIMIT-th mismatch is itself logged.
- FIFO full:
  - Push with no pop: record dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, no drop.
- Empty FIFO: log_valid=0 and log_data=0.
- clear has priority over concurrent samples and pops. The clear cycle's v1 is discarded.
- Counters saturate and never wrap.

## Timing
- Reset values: check_count=0, err_count=0, fail=0, overflow=0, log_valid=0, log_data=0. FSM=IDLE, v1=0, stamp=0.
- Latency: a sample taken at edge N updates the counters at edge N+2. Its record has log_valid=1 after edge N+2, provided the FIFO was empty.
- Handshake: a pop occurs when log_valid && log_ready at the rising edge. log_data is stable while log_valid=1 and log_ready=0.
- FIFO is first-word-fall-through from registered storage; no combinational path from log_ready to log_valid.
- Reset asserted mid-operation clears everything immediately. The in-flight stage-1/2 sample is lost.
- fail rises in the same cycle err_count equals ERR_LIMIT.

## Structure
- Package out_checker_pkg holds:
  - state enum {IDLE, RUN, FAIL}
  - LOG_W=19 and the field offsets MASK_LSB=16, STAMP_LSB=0
  - lane bit indices SMALL=0, QUAD=1, WIDE=2
- One sub-module, chk_fifo: parameterised width/depth, FWFT, full/empty flags, simultaneous push/pop support.
- The compare pipeline and FSM live in out_checker.

## Test plan
- Reset release: dut_reset_l=1, in_small=1, in_quad=5, in_wide=7, outs 2/6/8, sample_en for 10 cycles -> check_count=10, err_count=0, log_valid=0, fail=0.
- Wrap and DUT reset:
  - in_small=3, out_small=0, in_quad=2^40-1, out_quad=0 -> no error.
  - dut_reset_l=0 with outs 0 -> no error.
  - dut_reset_l=0 with out_wide=1 -> one record with lane_mask=3'b100.
- Error limit: ERR_LIMIT=4, inject 6 mismatches on out_quad -> err_count=6, fail=1, exactly 4 records each with mask 3'b010 and increasing stamps.
- FIFO overflow: LOG_AW=3, ERR_LIMIT=20, log_ready=0, 10 mismatches -> 8 records retained, overflow=1. Then a push concurrent with a pop when full -> no additional drop.
- Backpressure: toggle log_ready randomly during 3 mismatches -> records emerge in order and log_data holds while stalled.
- Mid-run: assert reset during FAIL -> all outputs return to reset values. Then clear during sample_en -> that sample is not counted.

Source files
------------

// File: rtl/out_checker_pkg.sv
// out_checker_pkg: FSM states, log record layout and lane indices
// shared by the output checker and its log FIFO.
package out_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAIL
    } state_e;

    localparam int LOG_W     = 19;
    localparam int MASK_LSB  = 16;
    localparam int STAMP_LSB = 0;

    localparam int SMALL = 0;
    localparam int QUAD  = 1;
    localparam int WIDE  = 2;

endpackage

// File: rtl/out_checker_fifo.sv
// chk_fifo: first-word-fall-through FIFO over registered storage.
// Ports: push/push_data in, pop/pop_data out, full/empty flags, sync clear.
module chk_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is accepted.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_checker.sv
// out_checker: recomputes expected DUT lane outputs, counts checks and
// mismatches, logs mismatch records {lane_mask, stamp} into a FIFO.
// Ports: clk, reset, sample_en, clear, dut_reset_l, in_*/out_* lanes,
// check_count, err_count, fail, overflow, log_valid/log_ready/log_data.
module out_checker
    import out_checker_pkg::*;
#(
    parameter int SMALL_W   = 2,
    parameter int QUAD_W    = 40,
    parameter int WIDE_W    = 70,
    parameter int LOG_AW    = 3,
    parameter int ERR_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic               clear,
    input  logic               dut_reset_l,
    input  logic [SMALL_W-1:0] in_small,
    input  logic [QUAD_W-1:0]  in_quad,
    input  logic [WIDE_W-1:0]  in_wide,
    input  logic [SMALL_W-1:0] out_small,
    input  logic [QUAD_W-1:0]  out_quad,
    input  logic [WIDE_W-1:0]  out_wide,
    output logic [31:0]        check_count,
    output logic [15:0]        err_count,
    output logic               fail,
    output logic               overflow,
    output logic               log_valid,
    input  logic               log_ready,
    output logic [LOG_W-1:0]   log_data
);

    localparam logic [15:0] LIMIT = 16'(ERR_LIMIT);

    logic               v1;
    logic               s1_rst_l;
    logic [SMALL_W-1:0] s1_in_small;
    logic [QUAD_W-1:0]  s1_in_quad;
    logic [WIDE_W-1:0]  s1_in_wide;
    logic [SMALL_W-1:0] s1_out_small;
    logic [QUAD_W-1:0]  s1_out_quad;
    logic [WIDE_W-1:0]  s1_out_wide;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1           <= 1'b0;
            s1_rst_l     <= 1'b0;
            s1_in_small  <= '0;
            s1_in_quad   <= '0;
            s1_in_wide   <= '0;
            s1_out_small <= '0;
            s1_out_quad  <= '0;
            s1_out_wide  <= '0;
        end else if (clear) begin
            v1 <= 1'b0;
        end else begin
            v1 <= sample_en;
            if (sample_en) begin
                s1_rst_l     <= dut_reset_l;
                s1_in_small  <= in_small;
                s1_in_quad   <= in_quad;
                s1_in_wide   <= in_wide;
                s1_out_small <= out_small;
                s1_out_quad  <= out_quad;
                s1_out_wide  <= out_wide;
            end
        end
    end

    logic [SMALL_W-1:0] exp_small;
    logic [QUAD_W-1:0]  exp_quad;
    logic [WIDE_W-1:0]  exp_wide;
    logic [2:0]         mask;

    always_comb begin
        exp_small = '0;
        exp_quad  = '0;
        exp_wide  = '0;
        if (s1_rst_l) begin
            exp_small = s1_in_small + SMALL_W'(1);
            exp_quad  = s1_in_quad + QUAD_W'(1);
            exp_wide  = s1_in_wide + WIDE_W'(1);
        end
        mask        = '0;
        mask[SMALL] = (s1_out_small != exp_small);
        mask[QUAD]  = (s1_out_quad != exp_quad);
        mask[WIDE]  = (s1_out_wide != exp_wide);
    end

    // Stage 2 registers the compare result with the stamp of the
    // cycle in which the compare was made.
    logic        v2;
    logic [2:0]  mask2;
    logic [15:0] stamp;
    logic [15:0] stamp2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2     <= 1'b0;
            mask2  <= '0;
            stamp  <= '0;
            stamp2 <= '0;
        end else if (clear) begin
            v2    <= 1'b0;
            stamp <= '0;
        end else begin
            v2     <= v1;
            mask2  <= mask;
            stamp  <= stamp + 16'd1;
            stamp2 <= stamp;
        end
    end

    state_e             state;
    logic               cnt_en;
    logic               mis;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [15:0]        err_nxt;
    logic [LOG_W-1:0]   push_data;

    assign cnt_en    = v2 && (state != IDLE);
    assign mis       = cnt_en && (mask2 != '0);
    assign push      = mis && (state == RUN);
    assign pop       = log_valid && log_ready;
    assign err_nxt   = (mis && err_count != 16'hFFFF)
                     ? err_count + 16'd1 : err_count;
    assign fail      = (state == FAIL);
    assign log_valid = !fifo_empty;

    always_comb begin
        push_data                   = '0;
        push_data[MASK_LSB +: 3]    = mask2;
        push_data[STAMP_LSB +: 16]  = stamp2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            check_count <= '0;
            err_count   <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            check_count <= '0;
            err_count   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (cnt_en && check_count != '1) begin
                check_count <= check_count + 32'd1;
            end
            err_count <= err_nxt;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            unique case (state)
                IDLE:    if (sample_en) state <= RUN;
                RUN:     if (mis && err_nxt == LIMIT) state <= FAIL;
                FAIL:    state <= FAIL;
                default: state <= IDLE;
            endcase
        end
    end

    chk_fifo #(
        .W  (LOG_W),
        .AW (LOG_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (log_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_out_checker.sv
// tb_out_checker: scoreboard bench for out_checker; expected log records
// are queued when samples are driven and compared as the FIFO drains.
module tb_out_checker;

    localparam int SW    = 2;
    localparam int QW    = 40;
    localparam int WW    = 70;
    localparam int AW    = 3;
    localparam int LIM   = 12;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_en;
    logic          clear;
    logic          dut_reset_l;
    logic [SW-1:0] in_small;
    logic [QW-1:0] in_quad;
    logic [WW-1:0] in_wide;
    logic [SW-1:0] out_small;
    logic [QW-1:0] out_quad;
    logic [WW-1:0] out_wide;
    logic [31:0]   check_count;
    logic [15:0]   err_count;
    logic          fail;
    logic          overflow;
    logic          log_valid;
    logic          log_ready;
    logic [18:0]   log_data;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;

    always #5 clk = ~clk;

    out_checker #(
        .SMALL_W   (SW),
        .QUAD_W    (QW),
        .WIDE_W    (WW),
        .LOG_AW    (AW),
        .ERR_LIMIT (LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_en),
        .clear       (clear),
        .dut_reset_l (dut_reset_l),
        .in_small    (in_small),
        .in_quad     (in_quad),
        .in_wide     (in_wide),
        .out_small   (out_small),
        .out_quad    (out_quad),
        .out_wide    (out_wide),
        .check_count (check_count),
        .err_count   (err_count),
        .fail        (fail),
        .overflow    (overflow),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_data    (log_data)
    );

    task automatic chk(input string tag,
                       input logic [69:0] got,
                       input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Reference model
    int          m_state = 0;
    int          m_check = 0;
    int          m_err   = 0;
    bit          m_ovf   = 1'b0;
    logic [15:0] m_stamp = '0;
    bit          p1_v    = 1'b0;
    bit          p2_v    = 1'b0;
    logic [18:0] p1_rec  = '0;
    logic [18:0] p2_rec  = '0;
    logic [18:0] exp_q[$];

    function automatic logic [2:0] mask_now();
        logic [SW:0] es;
        logic [QW:0] eq;
        logic [WW:0] ew;
        es = '0;
        eq = '0;
        ew = '0;
        if (dut_reset_l) begin
            es = {1'b0, in_small} + (SW+1)'(1);
            eq = {1'b0, in_quad} + (QW+1)'(1);
            ew = {1'b0, in_wide} + (WW+1)'(1);
        end
        return {out_wide != ew[WW-1:0],
                out_quad != eq[QW-1:0],
                out_small != es[SW-1:0]};
    endfunction

    task automatic model_clear();
        m_state = 0;
        m_check = 0;
        m_err   = 0;
        m_ovf   = 1'b0;
        m_stamp = '0;
        p1_v    = 1'b0;
        p2_v    = 1'b0;
        exp_q.delete();
    endtask

    always @(posedge clk or posedge reset) begin : mdl
        bit popd;
        if (reset || clear) begin
            model_clear();
        end else begin
            popd = log_ready && (exp_q.size() != 0);
            if (popd) void'(exp_q.pop_front());
            if (p2_v && m_state != 0) begin
                m_check++;
                if (p2_rec[18:16] != 3'b000) begin
                    m_err++;
                    if (m_state == 1) begin
                        if (exp_q.size() < DEPTH)
                            exp_q.push_back(p2_rec);
                        else
                            m_ovf = 1'b1;
                        if (m_err == LIM) m_state = 2;
                    end
                end
            end
            p2_v    = p1_v;
            p2_rec  = p1_rec;
            m_stamp = m_stamp + 16'd1;
            p1_v    = sample_en;
            p1_rec  = {mask_now(), m_stamp};
            if (m_state == 0 && sample_en) m_state = 1;
        end
    end

    always @(negedge clk) begin
        chk("log_valid", 70'(log_valid), 70'(exp_q.size() != 0));
        chk("log_data", 70'(log_data),
            exp_q.size() != 0 ? 70'(exp_q[0]) : 70'd0);
        chk("fail", 70'(fail), 70'(m_state == 2));
        chk("overflow", 70'(overflow), 70'(m_ovf));
        chk("check_count", 70'(check_count), 70'(m_check));
        chk("err_count", 70'(err_count), 70'(m_err));
        if (log_valid && log_ready) n_pops++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic sample(input logic rl,
                          input logic [SW-1:0] is, input logic [SW-1:0] os,
                          input logic [QW-1:0] iq, input logic [QW-1:0] oq,
                          input logic [WW-1:0] iw, input logic [WW-1:0] ow);
        dut_reset_l = rl;
        in_small    = is;
        out_small   = os;
        in_quad     = iq;
        out_quad    = oq;
        in_wide     = iw;
        out_wide    = ow;
        sample_en   = 1'b1;
        tick();
        sample_en   = 1'b0;
    endtask

    task automatic drain();
        log_ready = 1'b1;
        for (int i = 0; i < 50 && log_valid; i++) tick();
        log_ready = 1'b0;
        tick();
        chk("drain_empty", 70'(log_valid), 70'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_check"}, 70'(check_count), 70'd0);
        chk({tag, "_err"}, 70'(err_count), 70'd0);
        chk({tag, "_fail"}, 70'(fail), 70'd0);
        chk({tag, "_ovf"}, 70'(overflow), 70'd0);
        chk({tag, "_valid"}, 70'(log_valid), 70'd0);
        chk({tag, "_data"}, 70'(log_data), 70'd0);
    endtask

    initial begin
        int          base;
        logic [2:0]  m;
        reset       = 1'b1;
        clear       = 1'b0;
        sample_en   = 1'b0;
        log_ready   = 1'b0;
        dut_reset_l = 1'b0;
        in_small    = '0;
        in_quad     = '0;
        in_wide     = '0;
        out_small   = '0;
        out_quad    = '0;
        out_wide    = '0;
        repeat (2) tick();
        chk_reset_vals("por");
        reset = 1'b0;
        tick();

        // Clean samples after DUT reset release
        dut_reset_l = 1'b1;
        in_small    = 2'd1;
        in_quad     = 40'd5;
        in_wide     = 70'd7;
        out_small   = 2'd2;
        out_quad    = 40'd6;
        out_wide    = 70'd8;
        sample_en   = 1'b1;
        repeat (10) tick();
        sample_en   = 1'b0;
        settle();
        chk("t1_check", 70'(check_count), 70'd10);
        chk("t1_err", 70'(err_count), 70'd0);
        chk("t1_valid", 70'(log_valid), 70'd0);
        chk("t1_fail", 70'(fail), 70'd0);

        // Lane wrap and DUT-in-reset expectations
        sample(1'b1, 2'd3, 2'd0, '1, '0, '1, '0);
        sample(1'b0, 2'd1, 2'd0, 40'd5, '0, 70'd7, '0);
        sample(1'b0, 2'd1, 2'd0, 40'd5, '0, 70'd7, 70'd1);
        settle();
        chk("t2_check", 70'(check_count), 70'd13);
        chk("t2_err", 70'(err_count), 70'd1);
        m = log_data[18:16];
        chk("t2_mask", 70'(m), 70'(3'b100));
        base = n_pops;
        drain();
        chk("t2_pops", 70'(n_pops - base), 70'd1);

        // Error limit with the log drained continuously
        pulse_clear();
        chk("clr_check", 70'(check_count), 70'd0);
        chk("clr_err", 70'(err_count), 70'd0);
        base = n_pops;
        log_ready = 1'b1;
        for (int i = 0; i < LIM + 2; i++)
            sample(1'b1, 2'd0, 2'd1, QW'(i), QW'(i + 2),
                   WW'(0), WW'(1));
        settle();
        log_ready = 1'b0;
        chk("t3_err", 70'(err_count), 70'(LIM + 2));
        chk("t3_check", 70'(check_count), 70'(LIM + 2));
        chk("t3_fail", 70'(fail), 70'd1);
        chk("t3_pops", 70'(n_pops - base), 70'(LIM));

        // Reset during FAIL with a sample in flight
        sample(1'b1, 2'd0, 2'd1, 40'd0, 40'd2, 70'd0, 70'd1);
        settle();
        chk("t4_check", 70'(check_count), 70'(LIM + 3));
        dut_reset_l = 1'b1;
        out_quad    = 40'd9;
        sample_en   = 1'b1;
        tick();
        sample_en   = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("mid");
        tick();
        reset = 1'b0;
        settle();
        chk("t4_lost", 70'(check_count), 70'd0);

        // FIFO fill, push+pop while full, then drop
        for (int i = 0; i < DEPTH; i++)
            sample(1'b1, 2'd0, 2'd1, 40'd0, 40'd1, WW'(i), WW'(0));
        settle();
        chk("t5_full_valid", 70'(log_valid), 70'd1);
        chk("t5_full_ovf", 70'(overflow), 70'd0);
        base = n_pops;
        sample(1'b1, 2'd0, 2'd1, 40'd0, 40'd1, 70'd20, 70'd0);
        tick();
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        tick();
        chk("t5_pushpop_ovf", 70'(overflow), 70'd0);
        chk("t5_pushpop_pops", 70'(n_pops - base), 70'd1);
        sample(1'b1, 2'd0, 2'd1, 40'd0, 40'd1, 70'd30, 70'd0);
        sample(1'b1, 2'd0, 2'd1, 40'd0, 40'd1, 70'd31, 70'd0);
        settle();
        chk("t5_drop_ovf", 70'(overflow), 70'd1);
        chk("t5_err", 70'(err_count), 70'(DEPTH + 3));
        chk("t5_fail", 70'(fail), 70'd0);
        base = n_pops;
        drain();
        chk("t5_pops", 70'(n_pops - base), 70'(DEPTH));

        // Random backpressure while records arrive
        pulse_clear();
        base = n_pops;
        for (int i = 0; i < 3; i++) begin
            log_ready = 1'($urandom_range(0, 1));
            sample(1'b1, 2'd1, 2'd0, 40'd0, 40'd1, 70'd0, 70'd1);
        end
        for (int i = 0; i < 30; i++) begin
            log_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        chk("t6_pops", 70'(n_pops - base), 70'd3);
        chk("t6_check", 70'(check_count), 70'd3);

        // Clear beats a concurrent sample and the in-flight one
        sample(1'b1, 2'd1, 2'd0, 40'd0, 40'd1, 70'd0, 70'd1);
        clear     = 1'b1;
        sample_en = 1'b1;
        tick();
        clear     = 1'b0;
        sample_en = 1'b0;
        settle();
        chk("t7_check", 70'(check_count), 70'd0);
        chk("t7_err", 70'(err_count), 70'd0);
        chk("t7_valid", 70'(log_valid), 70'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
